spi_req_arbiter: RTL
====================

Name: spi_req_arbiter

Overview:
- Shares one SPI master among NREQ requesters, one per chip-select.
- Uses round-robin arbitration.
- Accepts one transaction at a time from the winning requester and drives it into the master's recv (val/rdy/msg) interface, tagged with a chip-select address.
- Routes the master's send (response) message back only to the granted requester, then releases the grant.
- Sits between the per-peripheral client logic and the SPI master.

Parameters:
- NREQ, 2, number of requesters; also the number of chip-selects; legal range 2..8.
- NBITS, 32, width of request and response messages.
- AW, $clog2(NREQ), chip-select address width; derived, not overridable.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_val  in  NREQ  per-requester request valid.
- req_rdy  out  NREQ  per-requester request ready.
- req_msg  in  NREQ*NBITS  packed request messages; requester i occupies bits [i*NBITS +: NBITS].
- resp_val  out  NREQ  per-requester response valid.
- resp_rdy  in  NREQ  per-requester response ready.
- resp_msg  out  NBITS  response message, broadcast to all requesters; qualified by resp_val.
- spi_req_val  out  1  request valid to SPI master recv.
- spi_req_rdy  in  1  SPI master recv ready.
- spi_req_msg  out  NBITS  request payload to SPI master.
- spi_req_addr  out  AW  chip-select address for the current transaction.
- spi_resp_val  in  1  SPI master send valid.
- spi_resp_rdy  out  1  ready to SPI master send.
- spi_resp_msg  in  NBITS  SPI master send message.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All transfers complete on the rising edge of clk when val && rdy.
- Reset: state=IDLE, grant=0, prio=0, msg_reg=0. All outputs low: req_rdy, resp_val, spi_req_val, spi_resp_rdy, busy, spi_req_msg=0, spi_req_addr=0.
- Reset asserted in any state returns the block to these values on the next edge. An in-flight SPI transaction is abandoned; the master is reset by the same signal.
- State IDLE:
  - winner = first i with req_val[i]=1, searching from prio upward and wrapping modulo NREQ.
  - req_rdy[winner]=1; all other req_rdy bits=0.
  - If any req_val is high: latch msg_reg=req_msg[winner] and grant=winner, go to ISSUE.
  - req_rdy is combinational on req_val (rdy-depends-on-val is permitted here only).
- State ISSUE:
  - spi_req_val=1, spi_req_msg=msg_reg, spi_req_addr=grant.
  - On spi_req_rdy=1, go to WAIT; otherwise hold with all outputs stable.
- State WAIT:
  - resp_val[grant]=spi_resp_val, resp_msg=spi_resp_msg, spi_resp_rdy=resp_rdy[grant].
  - All other resp_val bits=0.
  - On spi_resp_val && resp_rdy[grant]: prio=(grant+1) wrapped modulo NREQ (NREQ need not be a power of 2), go to IDLE.
- spi_resp_val in IDLE or ISSUE: spi_resp_rdy=0, response not consumed, no error.
- req_val of non-granted requesters during ISSUE/WAIT is ignored; those requests are not lost because rdy stays low.
- Latency: request accepted in cycle T; spi_req_val first high in cycle T+1. Minimum IDLE→IDLE round trip is 3 cycles.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after a response completes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... Starvation bound is NREQ-1 transactions.
- Grant update: prio updates only on response completion, not on acceptance.
- busy=1 in ISSUE and WAIT.

Decomposition:
- Shared package spi_arb_pkg holds:
  - the state_t enum {IDLE, ISSUE, WAIT} (2 bits);
  - a localparam for the reset value of prio.
- One natural sub-module: rr_pick. It is combinational and takes req_val[NREQ] and prio[AW]. It outputs winner[AW] and any_val.
- The state register, grant/prio/msg_reg registers and output muxing stay in spi_req_arbiter.

Test Plan:
- Reset then single request: req_val=2'b01, req_msg[0]=32'hA5A5_0001.
  - Required: req_rdy=2'b01 the same cycle.
  - Next cycle: spi_req_val=1, spi_req_addr=0, spi_req_msg=32'hA5A5_0001.
  - Return spi_resp_msg=32'h0000_1234 → resp_val=2'b01 with that message; busy drops afterwards.
- Both requesters continuously valid, master always ready and responding 1 cycle after accept, 6 transactions.
  - Required: spi_req_addr sequence 0,1,0,1,0,1.
  - resp_val asserted only to the matching requester each time.
- Master back-pressure: hold spi_req_rdy=0 for 5 cycles in ISSUE.
  - Required: spi_req_val, spi_req_msg and spi_req_addr stable for all 5 cycles.
  - req_rdy=0 throughout, including for a newly valid requester 1.
- Response back-pressure: grant=1, spi_resp_val=1, resp_rdy[1]=0 for 3 cycles, then 1.
  - Required: spi_resp_rdy=0 for 3 cycles, then a single completion.
  - State returns to IDLE; prio=0.
- Reset mid-WAIT: assert reset for 1 cycle while grant=1 with spi_resp_val=1.
  - Required: next cycle all outputs are at their reset values.
  - The following request from requester 1 is granted with spi_req_addr=1 (prio=0, only 1 is valid).
- Spurious spi_resp_val=1 in IDLE with no requests.
  - Required: spi_resp_rdy=0, resp_val=0, state stays IDLE.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and reset constants for the SPI requester arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned PRIO_RESET = 0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after prio, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 1
) (
    input  logic [NREQ-1:0] req_val,
    input  logic [AW-1:0]   prio,
    output logic [AW-1:0]   winner,
    output logic            any_val
);

    int unsigned idx;
    logic [AW-1:0] idx_t;

    always_comb begin
        winner  = '0;
        any_val = 1'b0;
        idx     = 0;
        idx_t   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            // explicit wrap so non-power-of-two NREQ stays in range
            idx = 32'(prio) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_t = AW'(idx);
            if (!any_val && req_val[idx_t]) begin
                any_val = 1'b1;
                winner  = idx_t;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master among NREQ requesters with round-robin grant and routed responses.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned NBITS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_val,
    output logic [NREQ-1:0]           req_rdy,
    input  logic [NREQ*NBITS-1:0]     req_msg,
    output logic [NREQ-1:0]           resp_val,
    input  logic [NREQ-1:0]           resp_rdy,
    output logic [NBITS-1:0]          resp_msg,
    output logic                      spi_req_val,
    input  logic                      spi_req_rdy,
    output logic [NBITS-1:0]          spi_req_msg,
    output logic [$clog2(NREQ)-1:0]   spi_req_addr,
    input  logic                      spi_resp_val,
    output logic                      spi_resp_rdy,
    input  logic [NBITS-1:0]          spi_resp_msg,
    output logic                      busy
);

    localparam int unsigned AW = $clog2(NREQ);

    state_t           state;
    logic [AW-1:0]    grant;
    logic [AW-1:0]    prio;
    logic [NBITS-1:0] msg_reg;

    logic [AW-1:0]    winner;
    logic             any_val;
    logic [NBITS-1:0] req_arr [NREQ];
    logic             resp_done;

    rr_pick #(
        .NREQ (NREQ),
        .AW   (AW)
    ) u_pick (
        .req_val (req_val),
        .prio    (prio),
        .winner  (winner),
        .any_val (any_val)
    );

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_arr[i] = req_msg[i*NBITS +: NBITS];
        end
    end

    assign resp_done = (state == WAIT) && spi_resp_val && resp_rdy[grant];

    // State, grant, priority and request payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            prio    <= AW'(PRIO_RESET);
            msg_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_val) begin
                        grant   <= winner;
                        msg_reg <= req_arr[winner];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (spi_req_rdy) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_done) begin
                        prio  <= (grant == AW'(NREQ - 1)) ? '0 : grant + AW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake routing; req_rdy depends on req_val only while idle
    always_comb begin
        req_rdy      = '0;
        resp_val     = '0;
        resp_msg     = '0;
        spi_resp_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (any_val) begin
                    req_rdy[winner] = 1'b1;
                end
            end
            WAIT: begin
                resp_val[grant] = spi_resp_val;
                resp_msg        = spi_resp_msg;
                spi_resp_rdy    = resp_rdy[grant];
            end
            default: ;
        endcase
    end

    assign spi_req_val  = (state == ISSUE);
    assign spi_req_msg  = msg_reg;
    assign spi_req_addr = grant;
    assign busy         = (state != IDLE);

endmodule
